// File: rtl/dpkt_pkg.sv
// Purpose: shared field widths, size helpers and header layout for the PE-side depacketizer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
// Packet layout (MSB..LSB): {type, dest, src, data}.
package dpkt_pkg;

    localparam int DPKT_DATA_W = 24;
    localparam int DPKT_ADDR_W = 4;
    localparam int DPKT_TYPE_W = 1;

    // Total packet width for a given field configuration.
    function automatic int pkt_w(input int type_w, input int addr_w, input int data_w);
        return type_w + 2 * addr_w + data_w;
    endfunction

    // One output per encodable type value.
    function automatic int num_out(input int type_w);
        return 1 << type_w;
    endfunction

    localparam int DPKT_PKT_W   = pkt_w(DPKT_TYPE_W, DPKT_ADDR_W, DPKT_DATA_W);
    localparam int DPKT_NUM_OUT = num_out(DPKT_TYPE_W);

    typedef struct packed {
        logic [DPKT_TYPE_W-1:0] ptype;
        logic [DPKT_ADDR_W-1:0] dest;
        logic [DPKT_ADDR_W-1:0] src;
    } dpkt_hdr_t;

    // Header fields of a default-width packet.
    function automatic dpkt_hdr_t get_hdr(input logic [DPKT_PKT_W-1:0] pkt);
        return pkt[DPKT_PKT_W-1 -: $bits(dpkt_hdr_t)];
    endfunction

    // Payload of a default-width packet.
    function automatic logic [DPKT_DATA_W-1:0] get_data(input logic [DPKT_PKT_W-1:0] pkt);
        return pkt[DPKT_DATA_W-1:0];
    endfunction

endpackage

// File: rtl/dpkt_fifo.sv
// Purpose: synchronous FIFO with registered count, full and empty flags.
// Latency: a push at edge t is visible at the head after edge t; head is shown combinationally.
// Backpressure: push ignored while full (no bypass on simultaneous pop); pop ignored while empty.
// Ports: clk/reset (sync, active-high); push_i/wdata_i write side; pop_i/rdata_o read side;
//        full_o/empty_o status. rdata_o keeps the last popped word while the FIFO is empty.
module dpkt_fifo #(
    parameter int WIDTH = 28,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             full_q, empty_q;
    logic [WIDTH-1:0] last_q;
    logic             do_push, do_pop;

    // Depth need not be a power of two, so wrap explicitly.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign do_push = push_i && !full_q;
    assign do_pop  = pop_i && !empty_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (do_push) wr_ptr_d = ptr_inc(wr_ptr_q);
        if (do_pop)  rd_ptr_d = ptr_inc(rd_ptr_q);
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            last_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= (cnt_d == CNT_W'(DEPTH));
            empty_q  <= (cnt_d == '0);
            if (do_pop) last_q <= mem_q[rd_ptr_q];
        end
    end

    // Storage is data-path only; validity is tracked by the count.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = empty_q ? last_q : mem_q[rd_ptr_q];
    assign full_o  = full_q;
    assign empty_o = empty_q;

endmodule

// File: rtl/dpkt_router_pe.sv
// Purpose: PE-side depacketizer; strips {type,dest} and steers {src,data} into FIFO[type].
// Latency: packet accepted at edge t shows out_valid[type]=1 after edge t; no comb in->out path.
// Backpressure: in_ready = !full[type] (1 for packets being dropped); outputs stall independently.
// Ports: clk, reset (sync, active-high); in_pkt/in_valid/in_ready input handshake;
//        out_data/out_src/out_valid/out_ready per output; drop_cnt saturating drop counter.
// Build option: define ADDR_FILTER_EN to discard packets whose dest != NODE_ADDR.
module dpkt_router_pe
    import dpkt_pkg::*;
#(
    parameter int                DATA_W     = 24,
    parameter int                ADDR_W     = 4,
    parameter int                TYPE_W     = 1,
    parameter int                FIFO_DEPTH = 2,
    parameter logic [ADDR_W-1:0] NODE_ADDR  = '0
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic [pkt_w(TYPE_W, ADDR_W, DATA_W)-1:0]       in_pkt,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    output logic [num_out(TYPE_W)-1:0][DATA_W-1:0]         out_data,
    output logic [num_out(TYPE_W)-1:0][ADDR_W-1:0]         out_src,
    output logic [num_out(TYPE_W)-1:0]                     out_valid,
    input  logic [num_out(TYPE_W)-1:0]                     out_ready,
    output logic [15:0]                                    drop_cnt
);

    localparam int NUM_OUT = num_out(TYPE_W);
    localparam int ENTRY_W = ADDR_W + DATA_W;

    logic [TYPE_W-1:0]  in_type;
    logic [ADDR_W-1:0]  in_dest;
    logic [ADDR_W-1:0]  in_src;
    logic [DATA_W-1:0]  in_data;
    logic [NUM_OUT-1:0] fifo_full;
    logic [NUM_OUT-1:0] fifo_empty;
    logic [NUM_OUT-1:0] fifo_push;
    logic               drop;
    logic               accept;

    assign {in_type, in_dest, in_src, in_data} = in_pkt;

`ifdef ADDR_FILTER_EN
    assign drop = (in_dest != NODE_ADDR);
`else
    assign drop = 1'b0;
    logic unused_dest;
    assign unused_dest = ^{in_dest, NODE_ADDR};
`endif

    // Dropped packets never touch a FIFO, so they are always accepted.
    assign in_ready = !reset && (drop || !fifo_full[in_type]);
    assign accept   = in_valid && in_ready;

    always_comb begin
        fifo_push = '0;
        if (accept && !drop) fifo_push[in_type] = 1'b1;
    end

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        logic [ENTRY_W-1:0] head;

        dpkt_fifo #(
            .WIDTH (ENTRY_W),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk     (clk),
            .reset   (reset),
            .push_i  (fifo_push[g]),
            .wdata_i ({in_src, in_data}),
            .pop_i   (out_ready[g]),
            .rdata_o (head),
            .full_o  (fifo_full[g]),
            .empty_o (fifo_empty[g])
        );

        assign out_src[g]   = head[DATA_W +: ADDR_W];
        assign out_data[g]  = head[DATA_W-1:0];
        assign out_valid[g] = !fifo_empty[g];
    end

`ifdef ADDR_FILTER_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (accept && drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) drop_cnt_q <= '0;
        else       drop_cnt_q <= drop_cnt_d;
    end

    assign drop_cnt = drop_cnt_q;
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_dpkt_router_pe.sv
// Purpose: self-checking bench for dpkt_router_pe (queue model plus directed literal checks).
// Latency: n/a.
// Backpressure: n/a.
module tb_dpkt_router_pe;

    localparam int          DW    = 24;
    localparam int          AW    = 4;
    localparam int          TW    = 1;
    localparam int          DEPTH = 2;
    localparam logic [3:0]  NODE  = 4'hD;

    logic              clk;
    logic              reset;
    logic [32:0]       in_pkt;
    logic              in_valid;
    logic              in_ready;
    logic [1:0][23:0]  out_data;
    logic [1:0][3:0]   out_src;
    logic [1:0]        out_valid;
    logic [1:0]        out_ready;
    logic [15:0]       drop_cnt;

    dpkt_router_pe #(
        .DATA_W     (DW),
        .ADDR_W     (AW),
        .TYPE_W     (TW),
        .FIFO_DEPTH (DEPTH),
        .NODE_ADDR  (NODE)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_pkt    (in_pkt),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [27:0] mq [2][$];
    int          mdrop = 0;

    function automatic bit m_drop(input logic [32:0] p);
`ifdef ADDR_FILTER_EN
        return p[31:28] != NODE;
`else
        return (p[31:28] === 4'hx);
`endif
    endfunction

    function automatic bit m_ready();
        if (reset) return 1'b0;
        if (m_drop(in_pkt)) return 1'b1;
        return mq[int'(in_pkt[32])].size() < DEPTH;
    endfunction

    bit acc_m;
    always @(posedge clk) begin
        if (reset) begin
            mq[0].delete();
            mq[1].delete();
            mdrop = 0;
        end else begin
            acc_m = in_valid && m_ready();
            for (int i = 0; i < 2; i++)
                if (out_ready[i] && mq[i].size() > 0) void'(mq[i].pop_front());
            if (acc_m) begin
                if (m_drop(in_pkt)) begin
                    if (mdrop < 65535) mdrop++;
                end else begin
                    mq[int'(in_pkt[32])].push_back(in_pkt[27:0]);
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_in_ready", in_ready, m_ready());
            for (int i = 0; i < 2; i++) begin
                check("m_out_valid", out_valid[i], mq[i].size() > 0);
                if (mq[i].size() > 0) begin
                    check("m_out_data", out_data[i], mq[i][0][23:0]);
                    check("m_out_src", out_src[i], mq[i][0][27:24]);
                end
            end
            check("m_drop_cnt", drop_cnt, mdrop);
        end
    end

    // ---------------- stimulus ----------------
    function automatic logic [32:0] mk(input bit t, input logic [3:0] d, input logic [3:0] s,
                                       input logic [23:0] data);
        return {t, d, s, data};
    endfunction

    task automatic drive(input bit v, input logic [32:0] p);
        in_valid = v;
        in_pkt   = p;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [23:0] got [$];
    bit          acc_t;
    int          d5;

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_pkt = '0; out_ready = 2'b00;
        cyc();
        chk_en = 1'b1;
        cyc();
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_out_valid", out_valid, 2'b00);
        reset = 1'b0;
        cyc();
        @(negedge clk);
        check("post_rst_out_valid", out_valid, 2'b00);
        check("post_rst_out_data", out_data, 48'h0);
        check("post_rst_out_src", out_src, 8'h0);
        check("post_rst_drop_cnt", drop_cnt, 16'h0);
        check("post_rst_in_ready", in_ready, 1'b1);

        // 1: single type-1 packet
        out_ready = 2'b11;
        drive(1'b1, mk(1'b1, 4'hD, 4'h3, 24'hAAAAAA));
        cyc();
        drive(1'b0, mk(1'b1, 4'hD, 4'h3, 24'hAAAAAA));
        @(negedge clk);
        check("t1_out_valid", out_valid, 2'b10);
        check("t1_out_data", out_data[1], 24'hAAAAAA);
        check("t1_out_src", out_src[1], 4'h3);
        cyc();

        // 2: fill FIFO 0, third packet backpressured, then drain in order
        out_ready = 2'b00;
        drive(1'b1, mk(1'b0, 4'hD, 4'h1, 24'd1));
        cyc();
        drive(1'b1, mk(1'b0, 4'hD, 4'h1, 24'd2));
        cyc();
        drive(1'b1, mk(1'b0, 4'hD, 4'h1, 24'd3));
        @(negedge clk);
        check("t2_full_rdy", in_ready, 1'b0);
        cyc();
        @(negedge clk);
        check("t2_full_rdy_hold", in_ready, 1'b0);
        out_ready = 2'b01;
        got.delete();
        for (int k = 0; k < 10; k++) begin
            if (out_valid[0] && out_ready[0]) got.push_back(out_data[0]);
            acc_t = in_valid && in_ready;
            cyc();
            if (acc_t) in_valid = 1'b0;
            @(negedge clk);
        end
        check("t2_drain_count", got.size(), 3);
        if (got.size() == 3) begin
            check("t2_order0", got[0], 24'd1);
            check("t2_order1", got[1], 24'd2);
            check("t2_order2", got[2], 24'd3);
        end

        // 3: output 0 full and stalled, type-1 still passes
        out_ready = 2'b00;
        drive(1'b1, mk(1'b0, 4'hD, 4'h5, 24'd10));
        cyc();
        drive(1'b1, mk(1'b0, 4'hD, 4'h5, 24'd11));
        cyc();
        drive(1'b1, mk(1'b1, 4'hD, 4'h6, 24'd55));
        @(negedge clk);
        check("t3_rdy_other_type", in_ready, 1'b1);
        cyc();
        drive(1'b0, mk(1'b0, 4'hD, 4'h6, 24'd0));
        @(negedge clk);
        check("t3_out_valid", out_valid, 2'b11);
        check("t3_head0", out_data[0], 24'd10);
        check("t3_head1", out_data[1], 24'd55);
        out_ready = 2'b11;
        cyc(); cyc(); cyc();
        @(negedge clk);
        check("t3_drained", out_valid, 2'b00);

        // 4: one entry, simultaneous push and pop for 8 cycles
        out_ready = 2'b00;
        drive(1'b1, mk(1'b0, 4'hD, 4'h2, 24'd100));
        cyc();
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, mk(1'b0, 4'hD, 4'h2, 24'(101 + k)));
            out_ready = 2'b01;
            @(negedge clk);
            check("t4_head", out_data[0], 24'(100 + k));
            check("t4_valid", out_valid[0], 1'b1);
            check("t4_rdy", in_ready, 1'b1);
            cyc();
        end
        drive(1'b0, mk(1'b0, 4'hD, 4'h2, 24'd0));
        @(negedge clk);
        check("t4_last", out_data[0], 24'd108);
        cyc();
        @(negedge clk);
        check("t4_empty", out_valid[0], 1'b0);

        // 5: packets for another node
        out_ready = 2'b11;
        d5 = 0;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, mk(1'b0, 4'h2, 4'h7, 24'(200 + k)));
            cyc();
            @(negedge clk);
            if (out_valid[0]) d5++;
        end
        drive(1'b0, mk(1'b0, 4'hD, 4'h7, 24'd0));
        cyc();
        @(negedge clk);
`ifdef ADDR_FILTER_EN
        check("t5_drop_cnt", drop_cnt, 16'd3);
        check("t5_delivered", d5, 0);
`else
        check("t5_drop_cnt", drop_cnt, 16'd0);
        check("t5_delivered", d5, 3);
`endif

        // 6: reset with two entries buffered
        out_ready = 2'b00;
        drive(1'b1, mk(1'b0, 4'hD, 4'h1, 24'd300));
        cyc();
        drive(1'b1, mk(1'b0, 4'hD, 4'h1, 24'd301));
        cyc();
        drive(1'b1, mk(1'b1, 4'hD, 4'h4, 24'd302));
        reset = 1'b1;
        cyc();
        @(negedge clk);
        check("t6_rst_valid", out_valid, 2'b00);
        check("t6_rst_drop", drop_cnt, 16'd0);
        check("t6_rst_rdy", in_ready, 1'b0);
        reset = 1'b0;
        cyc();
        drive(1'b0, mk(1'b0, 4'hD, 4'h0, 24'd0));
        @(negedge clk);
        check("t6_new_valid", out_valid, 2'b10);
        check("t6_new_data", out_data[1], 24'd302);
        check("t6_new_src", out_src[1], 4'h4);

        cyc(); cyc();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
